sram_bus_master: RTL and testbench
==================================

// Module: sram_bus_master
// PURPOSE
//  Initiator for the 16-bit x 4M synchronous RAM port (clk, w_en, r_en, ce, ce2, lb, w_addr, r_addr, w_data, r_data).
//  Accepts single/burst read/write commands on a valid/ready interface from the Arduino Due bridge.
//  Drives RAM strobes and addresses; returns read data on a valid-only response stream.
//  Sits between the host command decoder and the memory block.
// PARAMETERS
//  AW      22  address width (words)
//  DW      16  data width
//  LW      8   burst length field width; burst = len+1 words (1..256)
//  RD_LAT  1   clocks from r_en sample edge to r_data valid
// PORTS
//  clk        in   1   system clock (12 MHz)
//  rst_n      in   1   asynchronous active-low reset
//  cmd_valid  in   1   command present
//  cmd_ready  out  1   block idle, command accepted when valid&ready
//  cmd_we     in   1   1=write burst, 0=read burst
//  cmd_addr   in   AW  start word address
//  cmd_len    in   LW  words-1
//  wr_valid   in   1   write data word present
//  wr_ready   out  1   write word consumed this cycle
//  wr_data    in   DW  write data
//  rsp_valid  out  1   read word valid (one cycle pulse, no backpressure)
//  rsp_data   out  DW  read word
//  busy       out  1   burst in progress
//  ce/ce2/lb  out  1   chip enables: ce=1, ce2=0, lb=1 while busy; ce=0, ce2=1, lb=0 idle
//  w_en,r_en  out  1   RAM write/read strobes
//  w_addr,r_addr out AW RAM addresses; w_data out DW; r_data in DW
// BEHAVIOUR
//  Reset (async assert, sync release): FSM=IDLE, cmd_ready=1, all strobes 0, addr/data 0, ce=0, ce2=1, lb=0, rsp_valid=0.
//  FSM: IDLE -> EN (cmd accepted; latch addr/len/we; assert ce/ce2/lb) -> WR or RD -> DRAIN -> IDLE.
//  EN: one cycle, enables settle before first strobe.
//  WR: when wr_valid, w_en=1, w_addr=cur, w_data=wr_data, wr_ready=1; else w_en=0 (stall, no timeout).
//  RD: r_en=1, r_addr=cur every cycle until last word issued; one read per clock.
//  Per issued word: cur=cur+1 mod 2^AW (0x3FFFFF wraps to 0x000000), remaining--.
//  Read response: r_data registered RD_LAT cycles after r_en edge -> rsp_valid/rsp_data, in issue order.
//  DRAIN: read waits until all RD_LAT responses returned; write 1 cycle. Then enables drop, IDLE.
//  cmd_ready=1 only in IDLE; commands while busy are not accepted (held by source).
//  r_en and w_en never both 1; addresses/data forced 0 when corresponding strobe is 0.
//  Reset mid-burst: strobes drop immediately (async), outstanding responses discarded.
// CONFIGURATION
//  SRAM_STATS_EN defined: adds outputs wr_count[31:0], rd_count[31:0]; +1 per w_en / r_en cycle;
//    saturate at 0xFFFFFFFF; cleared by rst_n only.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package sram_bus_pkg: AW/DW/LW defaults, state enum (IDLE,EN,WR,RD,DRAIN), enable idle/active constants.
//  Sub-module sram_rd_pipe: RD_LAT-deep valid shift register aligning r_data to rsp_valid, plus outstanding counter.
// TESTING
//  1 Reset: rst_n=0 mid-sim -> ce=0,ce2=1,lb=0,w_en=r_en=0,cmd_ready=1 same cycle.
//  2 Write addr 0x0F len 0 data 0xA5 then read 0x0F len 0 -> one w_en at 0x0F, rsp_data=0x00A5, rsp_valid 1 pulse.
//  3 Read burst addr 0x00 len 255 on mem_init image -> 256 back-to-back r_en, rsp_data == init[i] in order.
//  4 Write burst addr 0x3FFFFE len 3, data 1..4 -> w_addr 0x3FFFFE,0x3FFFFF,0x000000,0x000001.
//  5 Write burst with wr_valid low 3 cycles mid-burst -> w_en gaps match, no word lost/duplicated.
//  6 SRAM_STATS_EN build, run 2+3 -> wr_count=1, rd_count=257.

Source files
------------

// File: rtl/sram_bus_pkg.sv
// Shared defaults, FSM state type and chip-enable encodings for the SRAM bus master.
package sram_bus_pkg;

    localparam int unsigned DEF_AW     = 22;
    localparam int unsigned DEF_DW     = 16;
    localparam int unsigned DEF_LW     = 8;
    localparam int unsigned DEF_RD_LAT = 1;

    typedef enum logic [2:0] {
        IDLE,
        EN,
        WR,
        RD,
        DRAIN
    } state_t;

    // Packed as {ce, ce2, lb}
    localparam logic [2:0] ENABLES_IDLE   = 3'b010;
    localparam logic [2:0] ENABLES_ACTIVE = 3'b101;

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-response alignment: RD_LAT-deep valid pipe pairing r_data with rsp_valid,
// plus a count of reads issued but not yet returned.
module sram_rd_pipe
    import sram_bus_pkg::*;
#(
    parameter int unsigned DW     = DEF_DW,
    parameter int unsigned RD_LAT = DEF_RD_LAT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          issue,
    input  logic [DW-1:0] r_data,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          empty
);

    localparam int unsigned CW = $clog2(RD_LAT + 2);

    logic [RD_LAT-1:0] vld;
    logic [CW-1:0]     pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld       <= '0;
            pending   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            vld[0] <= issue;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                vld[i] <= vld[i-1];
            end
            rsp_valid <= vld[RD_LAT-1];
            rsp_data  <= vld[RD_LAT-1] ? r_data : '0;
            case ({issue, vld[RD_LAT-1]})
                2'b10:   pending <= pending + CW'(1);
                2'b01:   pending <= pending - CW'(1);
                default: pending <= pending;
            endcase
        end
    end

    assign empty = (pending == '0);

endmodule

// File: rtl/sram_bus_master.sv
// Burst initiator for the 16-bit synchronous RAM port.
// Build option SRAM_STATS_EN adds saturating wr_count/rd_count strobe counters.
module sram_bus_master
    import sram_bus_pkg::*;
#(
    parameter int unsigned AW     = DEF_AW,
    parameter int unsigned DW     = DEF_DW,
    parameter int unsigned LW     = DEF_LW,
    parameter int unsigned RD_LAT = DEF_RD_LAT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [LW-1:0] cmd_len,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          busy,
    output logic          ce,
    output logic          ce2,
    output logic          lb,
    output logic          w_en,
    output logic          r_en,
    output logic [AW-1:0] w_addr,
    output logic [AW-1:0] r_addr,
    output logic [DW-1:0] w_data,
    input  logic [DW-1:0] r_data
`ifdef SRAM_STATS_EN
    ,
    output logic [31:0]   wr_count,
    output logic [31:0]   rd_count
`endif
);

    state_t        state;
    logic [AW-1:0] cur;
    logic [LW:0]   remain;
    logic          we;
    logic          rd_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cmd_ready      <= 1'b1;
            busy           <= 1'b0;
            {ce, ce2, lb}  <= ENABLES_IDLE;
            wr_ready       <= 1'b0;
            w_en           <= 1'b0;
            r_en           <= 1'b0;
            w_addr         <= '0;
            r_addr         <= '0;
            w_data         <= '0;
            cur            <= '0;
            remain         <= '0;
            we             <= 1'b0;
        end else begin
            w_en   <= 1'b0;
            w_addr <= '0;
            w_data <= '0;
            r_en   <= 1'b0;
            r_addr <= '0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready     <= 1'b0;
                        busy          <= 1'b1;
                        {ce, ce2, lb} <= ENABLES_ACTIVE;
                        cur           <= cmd_addr;
                        remain        <= (LW+1)'(cmd_len) + (LW+1)'(1);
                        we            <= cmd_we;
                        state         <= EN;
                    end
                end
                EN: begin
                    if (we) begin
                        wr_ready <= 1'b1;
                        state    <= WR;
                    end else begin
                        r_en   <= 1'b1;
                        r_addr <= cur;
                        cur    <= cur + AW'(1);
                        remain <= remain - (LW+1)'(1);
                        state  <= RD;
                    end
                end
                WR: begin
                    // wr_ready is registered a cycle ahead, so it is already low
                    // on the edge after the last word has been taken.
                    if (wr_valid) begin
                        w_en   <= 1'b1;
                        w_addr <= cur;
                        w_data <= wr_data;
                        cur    <= cur + AW'(1);
                        remain <= remain - (LW+1)'(1);
                        if (remain == (LW+1)'(1)) begin
                            wr_ready <= 1'b0;
                            state    <= DRAIN;
                        end
                    end
                end
                RD: begin
                    if (remain != '0) begin
                        r_en   <= 1'b1;
                        r_addr <= cur;
                        cur    <= cur + AW'(1);
                        remain <= remain - (LW+1)'(1);
                    end else begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (we || rd_empty) begin
                        {ce, ce2, lb} <= ENABLES_IDLE;
                        busy          <= 1'b0;
                        cmd_ready     <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sram_rd_pipe #(
        .DW     (DW),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue     (r_en),
        .r_data    (r_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .empty     (rd_empty)
    );

`ifdef SRAM_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count <= '0;
            rd_count <= '0;
        end else begin
            if (w_en && (wr_count != '1)) wr_count <= wr_count + 32'd1;
            if (r_en && (rd_count != '1)) rd_count <= rd_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sram_bus_master.sv
// Randomised bench for sram_bus_master against a word-level memory/command model.
// Define SRAM_STATS_EN to also cover the strobe counters.
module tb_sram_bus_master;

    localparam int AW = 22;
    localparam int DW = 16;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          busy, ce, ce2, lb, w_en, r_en;
    logic [AW-1:0] w_addr, r_addr;
    logic [DW-1:0] w_data;
    logic [DW-1:0] r_data = '0;
`ifdef SRAM_STATS_EN
    logic [31:0]   wr_count, rd_count;
`endif

    always #5 clk = ~clk;

    sram_bus_master #(.AW(AW), .DW(DW), .LW(LW), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .ce(ce), .ce2(ce2), .lb(lb), .w_en(w_en), .r_en(r_en),
        .w_addr(w_addr), .r_addr(r_addr), .w_data(w_data), .r_data(r_data)
`ifdef SRAM_STATS_EN
        , .wr_count(wr_count), .rd_count(rd_count)
`endif
    );

    function automatic logic [15:0] init_val(input logic [21:0] a);
        logic [31:0] x;
        x = ({10'd0, a} * 32'd40503) ^ 32'h0000_5A5A;
        return x[15:0] ^ x[31:16];
    endfunction

    // RAM device model (1-clock read latency), preloaded with the init image
    logic [15:0] ram [int unsigned];
    always @(posedge clk) begin
        if (w_en) ram[w_addr] = w_data;
        if (r_en) r_data <= ram.exists(r_addr) ? ram[r_addr] : init_val(r_addr);
    end

    // Reference contents, updated per command
    logic [15:0] ref_mem [int unsigned];
    function automatic logic [15:0] ref_rd(input logic [21:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [21:0] exp_waddr[$], exp_raddr[$];
    logic [15:0] exp_wdata[$], exp_rsp[$];
    logic [15:0] wbuf[$];
    int cyc = 0, mon_wcnt = 0, mon_rcnt = 0, mon_rspcnt = 0, mon_wgaps = 0, mon_rgaps = 0;
    int w_last = 0, r_last = 0;
    bit w_seen = 0, r_seen = 0, mon_on = 1;
    longint exp_wr_total = 0, exp_rd_total = 0;

    task automatic mon_step();
        cyc++;
        if (!rst_n || !mon_on) return;
        if (cmd_ready) begin
            w_seen = 0;
            r_seen = 0;
        end
        if (w_en || r_en) begin
            check_eq("strobe_excl", w_en & r_en, 0);
            check_eq("en_during_strobe", {ce, ce2, lb}, 3'b101);
        end
        if (w_en) begin
            mon_wcnt++;
            if (w_seen) mon_wgaps += cyc - w_last - 1;
            w_seen = 1;
            w_last = cyc;
            check_eq("r_bus_zero", {r_addr}, 0);
            if (exp_waddr.size() == 0) check_eq("w_en_unexpected", w_en, 0);
            else begin
                check_eq("w_addr", w_addr, exp_waddr.pop_front());
                check_eq("w_data", w_data, exp_wdata.pop_front());
            end
        end
        if (r_en) begin
            mon_rcnt++;
            if (r_seen) mon_rgaps += cyc - r_last - 1;
            r_seen = 1;
            r_last = cyc;
            check_eq("w_bus_zero", {w_addr, w_data}, 0);
            if (exp_raddr.size() == 0) check_eq("r_en_unexpected", r_en, 0);
            else check_eq("r_addr", r_addr, exp_raddr.pop_front());
        end
        if (rsp_valid) begin
            mon_rspcnt++;
            if (exp_rsp.size() == 0) check_eq("rsp_unexpected", rsp_valid, 0);
            else check_eq("rsp_data", rsp_data, exp_rsp.pop_front());
        end
    endtask

    task automatic wait_ready();
        int i;
        for (i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        if (i == 2000) check_eq("idle_timeout", cmd_ready, 1);
        check_eq("idle_enables", {ce, ce2, lb}, 3'b010);
        check_eq("idle_busy", busy, 0);
    endtask

    task automatic issue_cmd(input bit we, input logic [21:0] addr, input logic [7:0] len);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_len   = len;
        @(negedge clk);
        cmd_valid = 1'b0;
        check_eq("accept_enables", {ce, ce2, lb}, 3'b101);
        check_eq("accept_ready", {busy, cmd_ready}, 2'b10);
    endtask

    task automatic run_write(input logic [21:0] addr, input int len,
                             input int stall_at, input int stall_len, input int pct);
        int n, idx, c0, g0, exp_gaps, left_stall;
        bit fire;
        logic [21:0] a;
        n = len + 1;
        c0 = mon_wcnt;
        g0 = mon_wgaps;
        exp_gaps = 0;
        left_stall = stall_len;
        for (int i = 0; i < n; i++) begin
            a = addr + 22'(i);
            exp_waddr.push_back(a);
            exp_wdata.push_back(wbuf[i]);
            ref_mem[a] = wbuf[i];
        end
        exp_wr_total += n;
        issue_cmd(1'b1, addr, 8'(len));
        idx = 0;
        fire = 0;
        for (int t = 0; t < 4000; t++) begin
            if (fire) idx++;
            if (idx == n) break;
            wr_data  = wbuf[idx];
            wr_valid = 1'b1;
            if (wr_ready && idx > 0 &&
                ((idx == stall_at && left_stall > 0) || ($urandom_range(0, 99) < pct))) begin
                wr_valid = 1'b0;
                exp_gaps++;
                if (idx == stall_at && left_stall > 0) left_stall--;
            end
            fire = wr_valid && wr_ready;
            @(negedge clk);
        end
        wr_valid = 1'b0;
        if (idx != n) check_eq("wr_feed_timeout", idx, n);
        wait_ready();
        check_eq("wr_words", mon_wcnt - c0, n);
        check_eq("wr_gaps", mon_wgaps - g0, exp_gaps);
        check_eq("wr_queue_left", exp_waddr.size(), 0);
        wbuf.delete();
    endtask

    task automatic run_read(input logic [21:0] addr, input int len);
        int r0, g0, s0;
        logic [21:0] a;
        r0 = mon_rcnt;
        g0 = mon_rgaps;
        s0 = mon_rspcnt;
        for (int i = 0; i <= len; i++) begin
            a = addr + 22'(i);
            exp_raddr.push_back(a);
            exp_rsp.push_back(ref_rd(a));
        end
        exp_rd_total += len + 1;
        issue_cmd(1'b0, addr, 8'(len));
        wait_ready();
        check_eq("rd_strobes", mon_rcnt - r0, len + 1);
        check_eq("rd_gaps", mon_rgaps - g0, 0);
        check_eq("rsp_count", mon_rspcnt - s0, len + 1);
        check_eq("rsp_queue_left", exp_rsp.size(), 0);
    endtask

    task automatic check_stats();
`ifdef SRAM_STATS_EN
        check_eq("wr_count", wr_count, exp_wr_total);
        check_eq("rd_count", rd_count, exp_rd_total);
`endif
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_enables", {ce, ce2, lb}, 3'b010);
        check_eq("rst_strobes", {w_en, r_en, rsp_valid, busy, wr_ready}, 0);
        check_eq("rst_cmd_ready", cmd_ready, 1);
        check_eq("rst_buses", {w_addr, r_addr, w_data}, 0);
        check_stats();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // single write then single read of the same word
        wbuf.push_back(16'h00A5);
        run_write(22'h00000F, 0, -1, 0, 0);
        run_read(22'h00000F, 0);
        // full 256-word read over the init image
        run_read(22'h000000, 255);
        check_stats();

        // write across the top-of-memory wrap, then read it back
        for (int i = 1; i <= 4; i++) wbuf.push_back(16'(i));
        run_write(22'h3FFFFE, 3, -1, 0, 0);
        run_read(22'h3FFFFE, 3);

        // three-cycle source stall mid-burst
        for (int i = 0; i < 10; i++) wbuf.push_back(16'($urandom));
        run_write(22'h001234, 9, 2, 3, 0);
        run_read(22'h001234, 9);

        for (int k = 0; k < 16; k++) begin
            logic [21:0] a;
            int len;
            a   = ($urandom_range(0, 3) == 0) ? 22'h3FFFF0 + 22'($urandom_range(0, 15))
                                               : 22'h000100 + 22'($urandom_range(0, 63));
            len = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i <= len; i++) wbuf.push_back(16'($urandom));
                run_write(a, len, -1, 0, 30);
            end else begin
                run_read(a, len);
            end
        end
        check_stats();

        // asynchronous reset in the middle of a long read burst
        mon_on = 0;
        issue_cmd(1'b0, 22'h000200, 8'd255);
        repeat (20) @(negedge clk);
        check_eq("pre_rst_r_en", r_en, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_enables", {ce, ce2, lb}, 3'b010);
        check_eq("midrst_strobes", {w_en, r_en}, 0);
        check_eq("midrst_ready", {cmd_ready, busy}, 2'b10);
        check_eq("midrst_rsp", rsp_valid, 0);
        exp_wr_total = 0;
        exp_rd_total = 0;
        check_stats();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("midrst_no_rsp", rsp_valid, 0);
        end
        rst_n = 1'b1;
        mon_on = 1;

        wbuf.push_back(16'hBEEF);
        wbuf.push_back(16'h1357);
        run_write(22'h000040, 1, -1, 0, 0);
        run_read(22'h00003F, 3);
        check_stats();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
